// File: rtl/fpu_ss_wb_arbiter.sv
// Write-back arbiter for the FP subsystem: merges FPnew results and memory
// results onto the FP register-file write port and the X result interface.
module fpu_ss_wb_arbiter #(
  parameter int unsigned MEM_BUF_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter int unsigned X_ID_WIDTH    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // FPnew result side
  input  logic                  fpu_out_valid_i,
  output logic                  fpu_out_ready_o,
  input  logic [4:0]            fpu_out_rd_i,
  input  logic                  fpu_out_rd_is_fp_i,
  input  logic [X_ID_WIDTH-1:0] fpu_out_id_i,
  input  logic [31:0]           fpu_out_data_i,
  // memory result side (no back-pressure)
  input  logic                  mem_res_valid_i,
  input  logic                  mem_res_we_i,
  input  logic [4:0]            mem_res_rd_i,
  input  logic [X_ID_WIDTH-1:0] mem_res_id_i,
  input  logic [31:0]           mem_res_data_i,
  // FP register-file write port
  output logic                  fpr_we_o,
  output logic [4:0]            fpr_waddr_o,
  output logic [31:0]           fpr_wdata_o,
  // X result interface
  output logic                  x_result_valid_o,
  input  logic                  x_result_ready_i,
  output logic [X_ID_WIDTH-1:0] x_result_id_o,
  output logic [31:0]           x_result_data_o,
  output logic                  x_result_src_mem_o,
  // status
  output logic                  mem_buf_full_o,
  output logic                  mem_buf_empty_o,
  output logic                  mem_overflow_o
);

  // Handshake: a result moves when x_result_valid_o & x_result_ready_i;
  // the FPnew side sees that moment as fpu_out_ready_o.

  localparam int unsigned PTR_W = (MEM_BUF_DEPTH > 1) ? $clog2(MEM_BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(MEM_BUF_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MEM_BUF_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  typedef struct packed {
    logic                  we;
    logic [4:0]            rd;
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           data;
  } mem_entry_t;

  mem_entry_t             buf_q [MEM_BUF_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [STV_W-1:0]       starve_q, starve_d;
  logic                   overflow_q, overflow_d;

  mem_entry_t             head;
  mem_entry_t             push_entry;
  logic                   buf_empty;
  logic                   buf_full;
  logic                   starved;
  logic                   fpu_sel;
  logic                   mem_sel;
  logic                   xfer;
  logic                   fpu_xfer;
  logic                   push;
  logic                   pop;

  // ---------------------------------------------------------------------------
  // FIFO status and head
  // ---------------------------------------------------------------------------
  assign buf_empty  = (count_q == '0);
  assign buf_full   = (count_q == DEPTH_C);
  assign head       = buf_q[rd_ptr_q];

  always_comb begin
    push_entry      = '0;
    push_entry.we   = mem_res_we_i;
    push_entry.rd   = mem_res_rd_i;
    push_entry.id   = mem_res_id_i;
    push_entry.data = mem_res_data_i;
  end

  // ---------------------------------------------------------------------------
  // Arbitration: memory by default, FPnew when the FIFO is empty or starved
  // ---------------------------------------------------------------------------
  assign starved  = (starve_q == LIMIT_C);
  assign fpu_sel  = fpu_out_valid_i & (buf_empty | starved);
  assign mem_sel  = ~buf_empty & ~fpu_sel;
  assign xfer     = (fpu_sel | mem_sel) & x_result_ready_i;
  assign fpu_xfer = fpu_sel & x_result_ready_i;
  assign pop      = mem_sel & x_result_ready_i;
  // A push into a full FIFO survives only if the head leaves this cycle.
  assign push     = mem_res_valid_i & (~buf_full | pop);

  always_comb begin
    fpu_out_ready_o    = fpu_xfer;
    x_result_valid_o   = fpu_sel | mem_sel;
    x_result_src_mem_o = mem_sel;
    fpr_we_o           = 1'b0;
    fpr_waddr_o        = '0;
    fpr_wdata_o        = '0;
    x_result_id_o      = '0;
    x_result_data_o    = '0;
    if (mem_sel) begin
      fpr_we_o        = xfer & head.we;
      fpr_waddr_o     = head.rd;
      fpr_wdata_o     = head.data;
      x_result_id_o   = head.id;
      x_result_data_o = head.data;
    end else if (fpu_sel) begin
      fpr_we_o        = xfer & fpu_out_rd_is_fp_i;
      fpr_waddr_o     = fpu_out_rd_i;
      fpr_wdata_o     = fpu_out_data_i;
      x_result_id_o   = fpu_out_id_i;
      x_result_data_o = fpu_out_data_i;
    end
  end

  assign mem_buf_full_o  = buf_full;
  assign mem_buf_empty_o = buf_empty;
  assign mem_overflow_o  = overflow_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (mem_res_valid_i & buf_full & ~pop) overflow_d = 1'b1;
  end

  // Counts cycles FPnew waits behind buffered memory results.
  always_comb begin
    starve_d = starve_q;
    if (!fpu_out_valid_i || fpu_xfer) begin
      starve_d = '0;
    end else if (!buf_empty && !starved) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      buf_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed bench for fpu_ss_wb_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, state updates on the rising edge.
module tb_fpu_ss_wb_arbiter;

  localparam int unsigned IDW = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           fpu_out_valid_i;
  logic           fpu_out_ready_o;
  logic [4:0]     fpu_out_rd_i;
  logic           fpu_out_rd_is_fp_i;
  logic [IDW-1:0] fpu_out_id_i;
  logic [31:0]    fpu_out_data_i;
  logic           mem_res_valid_i;
  logic           mem_res_we_i;
  logic [4:0]     mem_res_rd_i;
  logic [IDW-1:0] mem_res_id_i;
  logic [31:0]    mem_res_data_i;
  logic           fpr_we_o;
  logic [4:0]     fpr_waddr_o;
  logic [31:0]    fpr_wdata_o;
  logic           x_result_valid_o;
  logic           x_result_ready_i;
  logic [IDW-1:0] x_result_id_o;
  logic [31:0]    x_result_data_o;
  logic           x_result_src_mem_o;
  logic           mem_buf_full_o;
  logic           mem_buf_empty_o;
  logic           mem_overflow_o;

  int n_cmp = 0;
  int n_err = 0;

  fpu_ss_wb_arbiter #(
    .MEM_BUF_DEPTH(2),
    .STARVE_LIMIT (4),
    .X_ID_WIDTH   (IDW)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .fpu_out_valid_i   (fpu_out_valid_i),
    .fpu_out_ready_o   (fpu_out_ready_o),
    .fpu_out_rd_i      (fpu_out_rd_i),
    .fpu_out_rd_is_fp_i(fpu_out_rd_is_fp_i),
    .fpu_out_id_i      (fpu_out_id_i),
    .fpu_out_data_i    (fpu_out_data_i),
    .mem_res_valid_i   (mem_res_valid_i),
    .mem_res_we_i      (mem_res_we_i),
    .mem_res_rd_i      (mem_res_rd_i),
    .mem_res_id_i      (mem_res_id_i),
    .mem_res_data_i    (mem_res_data_i),
    .fpr_we_o          (fpr_we_o),
    .fpr_waddr_o       (fpr_waddr_o),
    .fpr_wdata_o       (fpr_wdata_o),
    .x_result_valid_o  (x_result_valid_o),
    .x_result_ready_i  (x_result_ready_i),
    .x_result_id_o     (x_result_id_o),
    .x_result_data_o   (x_result_data_o),
    .x_result_src_mem_o(x_result_src_mem_o),
    .mem_buf_full_o    (mem_buf_full_o),
    .mem_buf_empty_o   (mem_buf_empty_o),
    .mem_overflow_o    (mem_overflow_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // moves to the next falling edge; caller then drives inputs
  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    rst_i              = 1'b0;
    fpu_out_valid_i    = 1'b0;
    fpu_out_rd_i       = '0;
    fpu_out_rd_is_fp_i = 1'b0;
    fpu_out_id_i       = '0;
    fpu_out_data_i     = '0;
    mem_res_valid_i    = 1'b0;
    mem_res_we_i       = 1'b0;
    mem_res_rd_i       = '0;
    mem_res_id_i       = '0;
    mem_res_data_i     = '0;
    x_result_ready_i   = 1'b0;
  endtask

  task automatic drive_fpu(input logic v, input logic [4:0] rd, input logic fp,
                           input logic [IDW-1:0] id, input logic [31:0] data);
    fpu_out_valid_i    = v;
    fpu_out_rd_i       = rd;
    fpu_out_rd_is_fp_i = fp;
    fpu_out_id_i       = id;
    fpu_out_data_i     = data;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [IDW-1:0] id,
                           input logic [31:0] data);
    mem_res_valid_i = v;
    mem_res_we_i    = 1'b1;
    mem_res_rd_i    = rd;
    mem_res_id_i    = id;
    mem_res_data_i  = data;
  endtask

  // checks a memory-sourced result presented at the head
  task automatic chk_mem_head(input string tag, input logic [4:0] rd, input logic we_exp);
    chk({tag, "_valid"}, 32'(x_result_valid_o), 32'd1);
    chk({tag, "_src"},   32'(x_result_src_mem_o), 32'd1);
    chk({tag, "_addr"},  32'(fpr_waddr_o), 32'(rd));
    chk({tag, "_we"},    32'(fpr_we_o), 32'(we_exp));
    chk({tag, "_data"},  fpr_wdata_o, 32'h1000_0000 + 32'(rd));
    chk({tag, "_fprdy"}, 32'(fpu_out_ready_o), 32'd0);
  endtask

  initial begin
    drive_idle();
    rst_i = 1'b1;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
    settle();

    // reset state
    chk("rst_valid",  32'(x_result_valid_o), 32'd0);
    chk("rst_fprdy",  32'(fpu_out_ready_o), 32'd0);
    chk("rst_we",     32'(fpr_we_o), 32'd0);
    chk("rst_addr",   32'(fpr_waddr_o), 32'd0);
    chk("rst_empty",  32'(mem_buf_empty_o), 32'd1);
    chk("rst_full",   32'(mem_buf_full_o), 32'd0);
    chk("rst_ovf",    32'(mem_overflow_o), 32'd0);
    chk("rst_src",    32'(x_result_src_mem_o), 32'd0);

    // single FPnew result, first stalled then accepted
    next_cycle();
    drive_fpu(1'b1, 5'd5, 1'b1, 4'd3, 32'h3F80_0000);
    x_result_ready_i = 1'b0;
    settle();
    chk("fstall_valid", 32'(x_result_valid_o), 32'd1);
    chk("fstall_fprdy", 32'(fpu_out_ready_o), 32'd0);
    chk("fstall_we",    32'(fpr_we_o), 32'd0);
    next_cycle();
    x_result_ready_i = 1'b1;
    settle();
    chk("fpu_fprdy", 32'(fpu_out_ready_o), 32'd1);
    chk("fpu_we",    32'(fpr_we_o), 32'd1);
    chk("fpu_addr",  32'(fpr_waddr_o), 32'd5);
    chk("fpu_id",    32'(x_result_id_o), 32'd3);
    chk("fpu_data",  fpr_wdata_o, 32'h3F80_0000);
    chk("fpu_xdata", x_result_data_o, 32'h3F80_0000);
    chk("fpu_src",   32'(x_result_src_mem_o), 32'd0);

    // FPnew integer-destination result: handshake without register write
    next_cycle();
    drive_fpu(1'b1, 5'd9, 1'b0, 4'd6, 32'h0000_0042);
    settle();
    chk("fint_fprdy", 32'(fpu_out_ready_o), 32'd1);
    chk("fint_we",    32'(fpr_we_o), 32'd0);
    chk("fint_xdata", x_result_data_o, 32'h0000_0042);

    // single load: invisible in its arrival cycle, presented next cycle
    next_cycle();
    drive_fpu(1'b0, 5'd0, 1'b0, 4'd0, 32'd0);
    drive_mem(1'b1, 5'd7, 4'd2, 32'h1000_0007);
    settle();
    chk("ld0_valid", 32'(x_result_valid_o), 32'd0);
    chk("ld0_empty", 32'(mem_buf_empty_o), 32'd1);
    next_cycle();
    drive_mem(1'b0, 5'd0, 4'd0, 32'd0);
    settle();
    chk_mem_head("ld1", 5'd7, 1'b1);
    chk("ld1_id",    32'(x_result_id_o), 32'd2);
    chk("ld1_empty", 32'(mem_buf_empty_o), 32'd0);
    next_cycle();
    settle();
    chk("ld2_empty", 32'(mem_buf_empty_o), 32'd1);
    chk("ld2_valid", 32'(x_result_valid_o), 32'd0);

    // starvation: one load buffered, then FPnew held while loads stream in
    next_cycle();
    drive_mem(1'b1, 5'd10, 4'd10, 32'h1000_000A);
    next_cycle();
    drive_fpu(1'b1, 5'd20, 1'b1, 4'd9, 32'hAAAA_5555);
    for (int k = 0; k < 4; k++) begin
      drive_mem(1'b1, 5'(11 + k), 4'(11 + k), 32'h1000_0000 + 32'(11 + k));
      settle();
      chk_mem_head($sformatf("stv_deny%0d", k), 5'(10 + k), 1'b1);
      next_cycle();
    end
    drive_mem(1'b1, 5'd15, 4'd15, 32'h1000_000F);
    settle();
    chk("stv_grant_fprdy", 32'(fpu_out_ready_o), 32'd1);
    chk("stv_grant_src",   32'(x_result_src_mem_o), 32'd0);
    chk("stv_grant_addr",  32'(fpr_waddr_o), 32'd20);
    chk("stv_grant_we",    32'(fpr_we_o), 32'd1);
    chk("stv_grant_id",    32'(x_result_id_o), 32'd9);
    next_cycle();
    // counter is back at 0, so memory wins again over a new FPnew result
    drive_mem(1'b0, 5'd0, 4'd0, 32'd0);
    drive_fpu(1'b1, 5'd21, 1'b1, 4'd8, 32'h1234_5678);
    settle();
    chk("stv_full", 32'(mem_buf_full_o), 32'd1);
    chk_mem_head("stv_after", 5'd14, 1'b1);
    next_cycle();
    drive_fpu(1'b0, 5'd0, 1'b0, 4'd0, 32'd0);
    settle();
    chk_mem_head("stv_drain", 5'd15, 1'b1);
    next_cycle();
    settle();
    chk("stv_empty", 32'(mem_buf_empty_o), 32'd1);

    // overflow: three loads while the core stalls
    next_cycle();
    x_result_ready_i = 1'b0;
    drive_mem(1'b1, 5'd1, 4'd1, 32'h1000_0001);
    next_cycle();
    drive_mem(1'b1, 5'd2, 4'd2, 32'h1000_0002);
    settle();
    chk("ovf_p2_full", 32'(mem_buf_full_o), 32'd0);
    chk_mem_head("ovf_p2", 5'd1, 1'b0);
    next_cycle();
    drive_mem(1'b1, 5'd3, 4'd3, 32'h1000_0003);
    settle();
    chk("ovf_p3_full", 32'(mem_buf_full_o), 32'd1);
    chk("ovf_p3_ovf",  32'(mem_overflow_o), 32'd0);
    next_cycle();
    drive_mem(1'b0, 5'd0, 4'd0, 32'd0);
    settle();
    chk("ovf_set",   32'(mem_overflow_o), 32'd1);
    chk("ovf_full",  32'(mem_buf_full_o), 32'd1);
    next_cycle();
    x_result_ready_i = 1'b1;
    settle();
    chk_mem_head("ovf_out0", 5'd1, 1'b1);
    next_cycle();
    settle();
    chk_mem_head("ovf_out1", 5'd2, 1'b1);
    next_cycle();
    settle();
    chk("ovf_empty",  32'(mem_buf_empty_o), 32'd1);
    chk("ovf_valid",  32'(x_result_valid_o), 32'd0);
    chk("ovf_sticky", 32'(mem_overflow_o), 32'd1);

    // reset with two buffered entries and FPnew pending
    next_cycle();
    x_result_ready_i = 1'b0;
    drive_mem(1'b1, 5'd8, 4'd8, 32'h1000_0008);
    next_cycle();
    drive_mem(1'b1, 5'd9, 4'd9, 32'h1000_0009);
    next_cycle();
    drive_mem(1'b0, 5'd0, 4'd0, 32'd0);
    drive_fpu(1'b1, 5'd3, 1'b1, 4'd1, 32'h4000_0000);
    settle();
    chk("prst_full", 32'(mem_buf_full_o), 32'd1);
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    drive_fpu(1'b0, 5'd0, 1'b0, 4'd0, 32'd0);
    settle();
    chk("mrst_empty", 32'(mem_buf_empty_o), 32'd1);
    chk("mrst_full",  32'(mem_buf_full_o), 32'd0);
    chk("mrst_valid", 32'(x_result_valid_o), 32'd0);
    chk("mrst_ovf",   32'(mem_overflow_o), 32'd0);

    // full FIFO: push and pop in the same cycle, no overflow, order kept
    next_cycle();
    drive_mem(1'b1, 5'd4, 4'd4, 32'h1000_0004);
    next_cycle();
    drive_mem(1'b1, 5'd5, 4'd5, 32'h1000_0005);
    next_cycle();
    x_result_ready_i = 1'b1;
    drive_mem(1'b1, 5'd6, 4'd6, 32'h1000_0006);
    settle();
    chk("pp_full0", 32'(mem_buf_full_o), 32'd1);
    chk_mem_head("pp_out0", 5'd4, 1'b1);
    next_cycle();
    drive_mem(1'b0, 5'd0, 4'd0, 32'd0);
    settle();
    chk("pp_full1", 32'(mem_buf_full_o), 32'd1);
    chk("pp_ovf",   32'(mem_overflow_o), 32'd0);
    chk_mem_head("pp_out1", 5'd5, 1'b1);
    next_cycle();
    settle();
    chk_mem_head("pp_out2", 5'd6, 1'b1);
    chk("pp_full2", 32'(mem_buf_full_o), 32'd0);
    next_cycle();
    settle();
    chk("pp_empty", 32'(mem_buf_empty_o), 32'd1);
    chk("pp_valid", 32'(x_result_valid_o), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
